axi4lite_slave_regfile: RTL

//  AXI4-Lite slave (the DUT) with a bank of 32-bit registers. It consumes the

---
 rtl/axi4lite_pkg.sv | 23 ++
 rtl/axi4lite_regbank.sv | 53 +++++
 rtl/axi4lite_slave_regfile.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types and default sizing for the AXI4-Lite register-file slave.
package axi4lite_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_regbank.sv
// NUM_REGS x DATA_WIDTH register storage: byte-strobed synchronous write,
// asynchronous read, and per-port range flags derived from the word index.
module axi4lite_regbank
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-3:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    output logic                  wr_in_range,
    input  logic [ADDR_WIDTH-3:0] rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_in_range
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] REG_COUNT = IDX_W'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [SEL_W-1:0]      wr_sel;
    logic [SEL_W-1:0]      rd_sel;

    assign wr_in_range = (wr_idx < REG_COUNT);
    assign rd_in_range = (rd_idx < REG_COUNT);
    assign wr_sel      = wr_idx[SEL_W-1:0];
    assign rd_sel      = rd_idx[SEL_W-1:0];

    // Out-of-range reads return zero rather than an aliased register.
    assign rd_data = rd_in_range ? regs[rd_sel] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_sel][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave over a small register bank with independent write and read
// channel FSMs; out-of-range word indices answer SLVERR.
module axi4lite_slave_regfile
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [1:0]            dbg_state
);

    // Handshakes: a beat transfers on the rising edge where VALID && READY.
    // READY here depends only on registered state, never on VALID; once a
    // response VALID is raised, it and its payload hold until the handshake.

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-3:0] aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    resp_t                 bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    resp_t                 rresp_q;

    logic                  aw_fire, w_fire, ar_fire, wr_commit;
    logic [ADDR_WIDTH-3:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_in_range;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_in_range;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    // The later of the two beats may be in flight this cycle, so merge the
    // latched copy with the live bus when picking what to commit.
    assign wr_commit = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_idx    = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
    assign wr_data   = w_held ? w_data_q : WDATA;
    assign wr_strb   = w_held ? w_strb_q : WSTRB;

    axi4lite_regbank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regbank (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .wr_en       (wr_commit),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .wr_in_range (wr_in_range),
        .rd_idx      (ARADDR[ADDR_WIDTH-1:2]),
        .rd_data     (rd_data),
        .rd_in_range (rd_in_range)
    );

    // State registers for both channels.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            W_IDLE: if (wr_commit) wr_state_next = W_RESP;
            W_RESP: if (BREADY)    wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            R_IDLE: if (ar_fire) rd_state_next = R_DATA;
            R_DATA: if (RREADY)  rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                AWREADY = !aw_held;
                WREADY  = !w_held;
            end
            W_RESP: BVALID = 1'b1;
        endcase
    end

    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (rd_state)
            R_IDLE: ARREADY = 1'b1;
            R_DATA: RVALID  = 1'b1;
        endcase
    end

    // Beat latches and registered response payloads.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= AWADDR[ADDR_WIDTH-1:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
            end
            // The bank read is combinational, so a same-edge write is not yet visible.
            if (ar_fire) begin
                rdata_q <= rd_data;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign BRESP     = bresp_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign dbg_state = {wr_state, rd_state};

endmodule
